knn_vector_loader: RTL and testbench
====================================

KNN_VECTOR_LOADER -- requirements
Module: knn_vector_loader

Interface
REQ-001 SHALL have parameter N_FEAT, default 34: number of feature words per vector.
REQ-002 SHALL have parameter W, default 64: feature word width in bits.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_data and in_last are valid.
REQ-006 SHALL have port in_ready, output, 1: the loader accepts a word.
REQ-007 SHALL have port in_data, input, W: one feature word, signed two's complement, passed through unmodified.
REQ-008 SHALL have port in_last, input, 1: marks the final word of a vector.
REQ-009 SHALL have port out_valid, output, 1: out_x holds a complete vector.
REQ-010 SHALL have port out_ready, input, 1: the classifier consumes out_x.
REQ-011 SHALL have port out_x, output, N_FEAT*W: lane i at bits [i*W +: W]; lane 0 is the first word received.
REQ-012 SHALL have port len_err, output, 1: one-cycle pulse when a vector is dropped for wrong length.
REQ-013 SHALL have port vec_count, output, 16: count of vectors delivered, wrapping.

Function
REQ-014 SHALL accept an input word only on a cycle with in_valid && in_ready; an output transfer SHALL occur only on a cycle with out_valid && out_ready.
REQ-015 SHALL hold two vector buffers (ping-pong), each with a full flag, a write-select pointer and a read-select pointer.
REQ-016 SHALL keep a word index idx in the range 0..N_FEAT-1; each accepted word SHALL be written to lane idx of the write buffer, and idx SHALL then increment.
REQ-017 SHALL use a state machine with states FILL and RESYNC; the reset state SHALL be FILL.
REQ-018 In FILL, in_ready SHALL equal !full[wsel], taken from registered state only, with no combinational path from out_ready or in_valid.
REQ-019 In FILL, when a word is accepted with idx==N_FEAT-1 and in_last==1, the loader SHALL on the next edge set full[wsel], toggle wsel and clear idx.
REQ-020 In FILL, when a word is accepted with in_last==1 and idx<N_FEAT-1 (short vector), the loader SHALL drop the partial vector, clear idx, pulse len_err for 1 cycle and stay in FILL.
REQ-021 In FILL, when a word is accepted with idx==N_FEAT-1 and in_last==0 (long vector), the loader SHALL drop the vector, clear idx, pulse len_err for 1 cycle and go to RESYNC.
REQ-022 In RESYNC, in_ready SHALL be 1 and accepted words SHALL be discarded; an accepted word with in_last==1 SHALL return the state to FILL with idx=0, and SHALL NOT produce a second len_err.
REQ-023 out_valid SHALL equal full[rsel], and out_x SHALL present the buffer at rsel.
REQ-024 On an output transfer, the loader SHALL clear full[rsel], toggle rsel and increment vec_count modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-025 A buffer SHALL assert out_valid on the cycle after its final word is accepted (latency 1 cycle).
REQ-026 out_x SHALL remain stable while out_valid is 1 and no transfer has occurred.
REQ-027 A fill completion and an output transfer in the same cycle SHALL both take effect, with neither lost.
REQ-028 When both buffers are full, in_ready SHALL be 0; after one output transfer, in_ready SHALL return to 1 on the next cycle.
REQ-029 When N_FEAT==1, every word with in_last==1 SHALL complete a vector, and every word with in_last==0 SHALL cause a long-vector error (REQ-021).

Reset
REQ-030 While reset is 1, and asynchronously on its assertion, the loader SHALL set state=FILL, idx=0, wsel=0, rsel=0, full=00, vec_count=0, len_err=0, out_valid=0, in_ready=0.
REQ-031 After reset deasserts, in_ready SHALL be 1 from the first clock edge onward.
REQ-032 A reset asserted mid-vector SHALL discard all partial and full buffers; buffer contents need no reset, and out_x SHALL be don't-care while out_valid is 0.

Verification
REQ-033 Bench SHALL cover: words 0..33 with in_last on word 33, out_ready=1 -> out_valid high 1 cycle after word 33, lane 5 = 5, vec_count=1.
REQ-034 Bench SHALL cover: 3 back-to-back vectors with out_ready=0 -> in_ready drops after 68 accepted words; first vector retained; out_ready pulsed once -> in_ready returns next cycle, vec_count=1.
REQ-035 Bench SHALL cover: in_last on word 10 -> len_err 1-cycle pulse, no out_valid; the next 34-word vector is delivered correctly with lane 0 = its first word.
REQ-036 Bench SHALL cover: 40 words with in_last only on word 40 -> a single len_err at word 34, words 35..40 discarded, the next vector delivered correctly.
REQ-037 Bench SHALL cover: reset asserted after 20 words -> out_valid=0 and in_ready=0 immediately; after release, a fresh vector is delivered intact.
REQ-038 Bench SHALL cover: 65537 vectors delivered -> vec_count=0x0001.

Source files
------------

// File: rtl/knn_vector_loader_if.sv
// -----------------------------------------------------------------------------
// knn_vector_loader_if
// Stream-in / vector-out bundle for the k-NN feature vector loader.
//   in_valid, in_ready, in_data[W], in_last  : word stream from the feature source
//   out_valid, out_ready, out_x[N_FEAT*W]    : assembled vector to the classifier
//   len_err                                  : one-cycle pulse, vector dropped for bad length
//   vec_count[16]                            : vectors delivered, wrapping
// Modports: slave = the loader, master = the side driving words / consuming vectors.
// -----------------------------------------------------------------------------
interface knn_vector_loader_if #(
    parameter int N_FEAT = 34,
    parameter int W      = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [N_FEAT*W-1:0] out_x;
    logic                len_err;
    logic [15:0]         vec_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_x, len_err, vec_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_x, len_err, vec_count
    );
endinterface

// File: rtl/knn_vector_loader.sv
// -----------------------------------------------------------------------------
// knn_vector_loader
// Collects N_FEAT words of W bits into a vector and hands complete vectors to
// the classifier through a two-entry ping-pong buffer. Vectors whose length is
// not exactly N_FEAT are dropped with a len_err pulse; over-long vectors are
// skipped up to and including their in_last word.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : knn_vector_loader_if.slave (word stream in, vector out, status)
// -----------------------------------------------------------------------------
module knn_vector_loader #(
    parameter int N_FEAT = 34,
    parameter int W      = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    knn_vector_loader_if.slave   bus
);
    localparam int               IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef enum logic {FILL, RESYNC} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [1:0]       full_q, full_d;
    logic [15:0]      vec_count_q, vec_count_d;
    logic             len_err_q, len_err_d;
    logic             in_ready_q, in_ready_d;

    logic [W-1:0]     buf_q [2][N_FEAT];

    logic             accept;
    logic             xfer;
    logic             at_last;
    logic             wr_en;

    assign accept  = bus.in_valid && in_ready_q;
    assign xfer    = full_q[rsel_q] && bus.out_ready;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        full_d      = full_q;
        vec_count_d = vec_count_q;
        len_err_d   = 1'b0;
        wr_en       = 1'b0;

        // Drain and fill touch different buffers (a fill needs full[wsel]==0,
        // a drain needs full[rsel]==1), so both updates can apply together.
        if (xfer) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = !rsel_q;
            vec_count_d    = vec_count_q + 16'd1;
        end

        if (accept) begin
            if (state_q == FILL) begin
                wr_en = 1'b1;
                if (bus.in_last) begin
                    idx_d = '0;
                    if (at_last) begin
                        full_d[wsel_q] = 1'b1;
                        wsel_d         = !wsel_q;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end else if (at_last) begin
                    // Too long: report once, then skip to the end of this vector.
                    idx_d     = '0;
                    len_err_d = 1'b1;
                    state_d   = RESYNC;
                end else begin
                    idx_d = IDX_W'(idx_q + 1'b1);
                end
            end else if (bus.in_last) begin
                state_d = FILL;
            end
        end

        // Registered ready: derived from next state so the source never sees
        // a combinational path from out_ready or in_valid.
        in_ready_d = (state_d == RESYNC) || !full_d[wsel_d];
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            idx_q       <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            full_q      <= 2'b00;
            vec_count_q <= 16'd0;
            len_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            full_q      <= full_d;
            vec_count_q <= vec_count_d;
            len_err_q   <= len_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // NOTE: the vector storage is deliberately left out of reset; the full
    // flags alone say whether a buffer holds data, so contents are don't-care.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[wsel_q][idx_q] <= bus.in_data;
        end
    end

    for (genvar i = 0; i < N_FEAT; i++) begin : g_lane
        assign bus.out_x[i*W +: W] = buf_q[rsel_q][i];
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = full_q[rsel_q];
    assign bus.len_err   = len_err_q;
    assign bus.vec_count = vec_count_q;

endmodule

// File: tb/tb_knn_vector_loader.sv
// -----------------------------------------------------------------------------
// tb_knn_vector_loader
// Directed scenarios on a default (34 x 64) loader, checked every cycle against
// a transaction-level model (queue of completed vectors), plus a 1 x 8 loader
// used for the single-word-vector rules and the 16-bit counter wrap.
// -----------------------------------------------------------------------------
module tb_knn_vector_loader;
    localparam int NF = 34;
    localparam int WW = 64;
    localparam int VW = NF * WW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    knn_vector_loader_if #(.N_FEAT(NF), .W(WW)) bus ();
    knn_vector_loader_if #(.N_FEAT(1),  .W(8))  bus2 ();

    knn_vector_loader #(.N_FEAT(NF), .W(WW)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    knn_vector_loader #(.N_FEAT(1), .W(8)) u_dut_one (
        .clock (clk),
        .reset (rst),
        .bus   (bus2)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int err1   = 0;
    int err2   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lane(input logic [VW-1:0] x, input int i);
        return x[i*WW +: WW];
    endfunction

    function automatic logic [63:0] vec(input int v, input int j);
        return {8'(8'hC0 + v), 48'h0, 8'(j)};
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] cur_vec;
    int            cur_len   = 0;
    bit            resync    = 0;
    bit            post_rst  = 1;
    bit            err_pend  = 0;
    logic [15:0]   exp_count = 16'd0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_len   = 0;
            resync    = 0;
            post_rst  = 1;
            err_pend  = 0;
            exp_count = 16'd0;
            check("rst_in_ready",  bus.in_ready,  0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_len_err",   bus.len_err,   0);
            check("rst_vec_count", bus.vec_count, 0);
        end else begin
            bit exp_ready;
            bit exp_valid;
            bit acc;
            bit xfer;
            int first;
            exp_ready = post_rst ? 1'b0 : (resync ? 1'b1 : (exp_q.size() < 2));
            exp_valid = (exp_q.size() > 0);
            check("in_ready",  bus.in_ready,  exp_ready);
            check("out_valid", bus.out_valid, exp_valid);
            check("len_err",   bus.len_err,   err_pend);
            check("vec_count", bus.vec_count, exp_count);
            if (exp_valid) begin
                n_cmp++;
                first = -1;
                for (int i = 0; i < NF; i++)
                    if (first < 0 && lane(bus.out_x, i) !== lane(exp_q[0], i)) first = i;
                if (first >= 0) begin
                    n_fail++;
                    $display("FAIL out_x lane %0d: got %h expected %h",
                             first, lane(bus.out_x, first), lane(exp_q[0], first));
                end
            end
            // Advance the model across the coming edge.
            acc      = bus.in_valid && exp_ready;
            xfer     = bus.out_ready && exp_valid;
            post_rst = 0;
            err_pend = 0;
            if (xfer) begin
                void'(exp_q.pop_front());
                exp_count = exp_count + 16'd1;
            end
            if (acc) begin
                if (resync) begin
                    if (bus.in_last) resync = 0;
                end else begin
                    cur_vec[cur_len*WW +: WW] = bus.in_data;
                    cur_len++;
                    if (bus.in_last) begin
                        if (cur_len == NF) exp_q.push_back(cur_vec);
                        else err_pend = 1;
                        cur_len = 0;
                    end else if (cur_len == NF) begin
                        err_pend = 1;
                        resync   = 1;
                        cur_len  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.len_err)  err1++;
        if (!rst && bus2.len_err) err2++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [63:0] d, input logic last);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: word %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic send2(input logic [7:0] d, input logic last);
        bit done = 0;
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        bus2.in_last  = last;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus2.in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        bus2.in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send2_timeout: word %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
        #1;
        check("reset_in_ready_now",  bus.in_ready,  0);
        check("reset_out_valid_now", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_first_edge", bus.in_ready, 1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int e0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.in_last   = 1'b0;
        bus2.out_ready = 1'b0;

        // Basic vector, latency 1.
        do_reset();
        check("t1_vec_count_reset", bus.vec_count, 0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < NF; j++) send(64'(j), j == NF - 1);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_lane0",  lane(bus.out_x, 0),  64'd0);
        check("t1_lane5",  lane(bus.out_x, 5),  64'd5);
        check("t1_lane33", lane(bus.out_x, 33), 64'd33);
        @(posedge clk);
        #1;
        check("t1_vec_count", bus.vec_count, 16'd1);
        check("t1_out_valid_after", bus.out_valid, 0);

        // Back-pressure with both buffers full.
        do_reset();
        for (int v = 0; v < 2; v++)
            for (int j = 0; j < NF; j++) send(vec(v, j), j == NF - 1);
        bus.in_valid = 1'b1;
        bus.in_data  = vec(2, 0);
        bus.in_last  = 1'b0;
        @(negedge clk);
        check("t2_in_ready_full", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        check("t2_in_ready_held", bus.in_ready, 0);
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_retained_lane0",  lane(bus.out_x, 0),  vec(0, 0));
        check("t2_retained_lane33", lane(bus.out_x, 33), vec(0, 33));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("t2_in_ready_back", bus.in_ready, 1);
        check("t2_vec_count", bus.vec_count, 16'd1);
        check("t2_second_lane0", lane(bus.out_x, 0), vec(1, 0));
        for (int j = 0; j < NF; j++) send(vec(2, j), j == NF - 1);
        bus.out_ready = 1'b1;
        idle(6);
        check("t2_vec_count_all", bus.vec_count, 16'd3);

        // Short vector followed by a good one.
        do_reset();
        for (int j = 0; j <= 10; j++) send(vec(3, j), j == 10);
        check("t3_len_err", bus.len_err, 1);
        check("t3_no_valid", bus.out_valid, 0);
        for (int j = 0; j < NF; j++)
            send((j == 0) ? 64'hFFFF_FFFF_FFFF_FFFB : vec(6, j), j == NF - 1);
        check("t3_out_valid", bus.out_valid, 1);
        check("t3_lane0", lane(bus.out_x, 0), 64'hFFFF_FFFF_FFFF_FFFB);
        check("t3_lane1", lane(bus.out_x, 1), vec(6, 1));
        bus.out_ready = 1'b1;
        idle(3);
        check("t3_vec_count", bus.vec_count, 16'd1);

        // Long vector: 40 words, in_last on word 40.
        do_reset();
        bus.out_ready = 1'b1;
        e0 = err1;
        for (int j = 1; j <= 40; j++) begin
            send(vec(4, j), j == 40);
            if (j == 34) check("t4_len_err_at_34", bus.len_err, 1);
            if (j == 40) check("t4_no_second_err", bus.len_err, 0);
        end
        idle(2);
        check("t4_err_pulses", 64'(err1 - e0), 64'd1);
        check("t4_vec_count_none", bus.vec_count, 16'd0);
        for (int j = 0; j < NF; j++) send(vec(5, j), j == NF - 1);
        check("t4_lane0", lane(bus.out_x, 0), vec(5, 0));
        idle(3);
        check("t4_vec_count", bus.vec_count, 16'd1);

        // Reset mid-vector with a full buffer pending.
        do_reset();
        for (int j = 0; j < NF; j++) send(vec(7, j), j == NF - 1);
        for (int j = 0; j < 20; j++) send(vec(8, j), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_out_valid_async", bus.out_valid, 0);
        check("t5_in_ready_async",  bus.in_ready,  0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int j = 0; j < NF; j++) send(vec(9, j), j == NF - 1);
        check("t5_lane0",  lane(bus.out_x, 0),  vec(9, 0));
        check("t5_lane33", lane(bus.out_x, 33), vec(9, 33));
        idle(3);
        check("t5_vec_count", bus.vec_count, 16'd1);

        // Single-word vectors and counter wrap.
        do_reset();
        bus2.out_ready = 1'b1;
        e0 = err2;
        send2(8'h11, 1'b0);
        check("n1_long_err", bus2.len_err, 1);
        send2(8'h22, 1'b1);
        check("n1_resync_no_err", bus2.len_err, 0);
        check("n1_resync_no_valid", bus2.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("n1_err_count", 64'(err2 - e0), 64'd1);
        check("n1_vec_count_zero", bus2.vec_count, 16'd0);
        for (int i = 0; i < 65537; i++) begin
            send2(8'(i) ^ 8'hA5, 1'b1);
            if (i == 0) begin
                check("n1_first_valid", bus2.out_valid, 1);
                check("n1_first_data",  bus2.out_x,     8'hA5);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("n1_vec_count_wrap", bus2.vec_count, 16'h0001);
        check("n1_out_valid_idle", bus2.out_valid, 0);
        check("n1_err_count_final", 64'(err2 - e0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
